// File: rtl/mux_scan_arbiter.sv
// mux_scan_arbiter: round-robin scheduler for the shared 8:1 mux / 1:8 demux path.
// Only channels whose requester is active are scanned. A granted channel keeps the path
// for DWELL cycles, or until it drops its request.
// Optional feature macro: MUX_SCAN_BLANK_EN. When it is defined, the outputs go blank
// for BLANK cycles between grants so the demux does not ghost.
module mux_scan_arbiter #(
   parameter int          N     = 8,
   parameter int          SEL_W = 3,
   parameter int          CNT_W = 28,
   parameter int unsigned DWELL = 2**25
`ifdef MUX_SCAN_BLANK_EN
   ,
   parameter int unsigned BLANK = 4
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             hold,
   output logic [SEL_W-1:0] sel,
   output logic             sel_valid,
   output logic [N-1:0]     grant,
   output logic             adv
);

   typedef enum logic [1:0] {
      stIdle  = 2'd0,
      stDwell = 2'd1,
      stBlank = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
`ifdef MUX_SCAN_BLANK_EN
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK - 1);
`endif

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [N-1:0]       grant_q, grant_d;
   logic               valid_q, valid_d;
   logic               adv_q, adv_d;

   logic               hit;
   logic [SEL_W-1:0]   hitIdx;
   logic [SEL_W-1:0]   cand;
   logic               startGrant;
   logic               enterIdle;

   // Find the first requester after the last granted channel; that channel itself is checked last.
   always_comb begin
      hit    = 1'b0;
      hitIdx = '0;
      cand   = '0;
      for (int i = 1; i <= N; i++) begin
         cand = SEL_W'((int'(ptr_q) + i) % N);
         if (!hit && req[cand]) begin
            hit    = 1'b1;
            hitIdx = cand;
         end
      end
   end

   // Decide the next state and the registered outputs. While hold is high nothing moves and adv stays low.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      timer_d    = timer_q;
      grant_d    = grant_q;
      valid_d    = valid_q;
      adv_d      = 1'b0;
      startGrant = 1'b0;
      enterIdle  = 1'b0;

      if (!hold) begin
         case (state_q)
            stIdle: begin
               if (hit) begin
                  startGrant = 1'b1;
               end else begin
                  enterIdle = 1'b1;
               end
            end
            stDwell: begin
               if ((timer_q == '0) || !req[sel_q]) begin
`ifdef MUX_SCAN_BLANK_EN
                  state_d = stBlank;
                  grant_d = '0;
                  valid_d = 1'b0;
                  timer_d = BLANK_LOAD;
`else
                  if (hit) begin
                     startGrant = 1'b1;
                  end else begin
                     enterIdle = 1'b1;
                  end
`endif
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
`ifdef MUX_SCAN_BLANK_EN
            stBlank: begin
               if (timer_q == '0) begin
                  if (hit) begin
                     startGrant = 1'b1;
                  end else begin
                     enterIdle = 1'b1;
                  end
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
`endif
            default: begin
               enterIdle = 1'b1;
            end
         endcase

         if (startGrant) begin
            state_d = stDwell;
            sel_d   = hitIdx;
            ptr_d   = hitIdx;
            grant_d = N'(1) << hitIdx;
            valid_d = 1'b1;
            adv_d   = 1'b1;
            timer_d = DWELL_LOAD;
         end else if (enterIdle) begin
            state_d = stIdle;
            grant_d = '0;
            valid_d = 1'b0;
         end
      end
   end

   // State and output registers. The pointer resets to N-1 so that the first search starts at channel 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= stIdle;
         sel_q   <= '0;
         ptr_q   <= SEL_W'(N - 1);
         timer_q <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         adv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         adv_q   <= adv_d;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = valid_q;
   assign grant     = grant_q;
   assign adv       = adv_q;

endmodule
